// File: rtl/ex_shift_stage.sv
// Execute-stage shift unit: SLL/SRA/ROR on a 16-bit operand, registered into EX/MEM,
// with Z flag update, stall/flush handling and a retired-shift counter.
module ex_shift_stage #(
    parameter int unsigned CNT_W   = 16,
    parameter logic        Z_RESET = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       in_op,
    input  logic [15:0]      in_data,
    input  logic [3:0]       in_imm,
    input  logic [3:0]       in_dst,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    output logic [15:0]      out_result,
    output logic [3:0]       out_dst,
    output logic             out_we,
    output logic             flag_z,
    output logic [CNT_W-1:0] shift_cnt
);

    localparam logic [1:0] OpSll = 2'b00;
    localparam logic [1:0] OpSra = 2'b01;
    localparam logic [1:0] OpRor = 2'b10;
    localparam logic [1:0] OpIll = 2'b11;

    logic [15:0]      result;
    logic [31:0]      ror_dbl;
    logic             op_legal;

    logic             out_valid_d, out_valid_q;
    logic [15:0]      out_result_d, out_result_q;
    logic [3:0]       out_dst_d, out_dst_q;
    logic             out_we_d, out_we_q;
    logic             flag_z_d, flag_z_q;
    logic [CNT_W-1:0] shift_cnt_d, shift_cnt_q;

    assign op_legal = (in_op != OpIll);

    // Rotate by shifting a doubled copy; the low half is the rotated word, n=0 included.
    always_comb begin
        ror_dbl = {in_data, in_data} >> in_imm;
        result  = in_data;
        unique case (in_op)
            OpSll:   result = in_data << in_imm;
            OpSra:   result = $signed(in_data) >>> in_imm;
            OpRor:   result = ror_dbl[15:0];
            default: result = in_data;
        endcase
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_dst_d    = out_dst_q;
        out_we_d     = out_we_q;
        flag_z_d     = flag_z_q;
        shift_cnt_d  = shift_cnt_q;
        if (flush) begin
            out_valid_d = 1'b0;
            out_we_d    = 1'b0;
        end else if (!stall) begin
            out_valid_d  = in_valid;
            out_result_d = result;
            out_dst_d    = in_dst;
            out_we_d     = in_valid & op_legal;
            if (in_valid && op_legal) begin
                flag_z_d    = (result == 16'h0000);
                shift_cnt_d = shift_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= 16'h0000;
            out_dst_q    <= 4'h0;
            out_we_q     <= 1'b0;
            flag_z_q     <= Z_RESET;
            shift_cnt_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_dst_q    <= out_dst_d;
            out_we_q     <= out_we_d;
            flag_z_q     <= flag_z_d;
            shift_cnt_q  <= shift_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_dst    = out_dst_q;
    assign out_we     = out_we_q;
    assign flag_z     = flag_z_q;
    assign shift_cnt  = shift_cnt_q;

endmodule

// File: tb/tb_ex_shift_stage.sv
// Self-checking bench for ex_shift_stage: directed vector table, hand-written stall/flush/
// illegal/wrap sequences, then randomized traffic against an arithmetic reference model.
module tb_ex_shift_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid, stall, flush;
    logic [1:0]  in_op;
    logic [15:0] in_data;
    logic [3:0]  in_imm, in_dst;

    logic        out_valid, out_we, flag_z;
    logic [15:0] out_result;
    logic [3:0]  out_dst;
    logic [15:0] shift_cnt;

    logic        out_valid2, out_we2, flag_z2;
    logic [15:0] out_result2;
    logic [3:0]  out_dst2;
    logic [1:0]  shift_cnt2;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic        m_valid, m_we, m_z, m_z2;
    logic [15:0] m_result;
    logic [3:0]  m_dst;
    int unsigned m_cnt;

    always #5 clk = ~clk;

    ex_shift_stage #(.CNT_W(16), .Z_RESET(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_op(in_op), .in_data(in_data),
        .in_imm(in_imm), .in_dst(in_dst), .stall(stall), .flush(flush),
        .out_valid(out_valid), .out_result(out_result), .out_dst(out_dst), .out_we(out_we),
        .flag_z(flag_z), .shift_cnt(shift_cnt)
    );

    ex_shift_stage #(.CNT_W(2), .Z_RESET(1'b1)) u_dut_w2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_op(in_op), .in_data(in_data),
        .in_imm(in_imm), .in_dst(in_dst), .stall(stall), .flush(flush),
        .out_valid(out_valid2), .out_result(out_result2), .out_dst(out_dst2), .out_we(out_we2),
        .flag_z(flag_z2), .shift_cnt(shift_cnt2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Shift semantics by plain integer arithmetic.
    function automatic logic [15:0] ref_shift(input logic [1:0] op, input logic [15:0] d,
                                              input logic [3:0] n);
        int unsigned u, p;
        int s, q;
        u = d;
        p = 32'd1 << n;
        case (op)
            2'd0: return 16'((u * p) % 65536);
            2'd1: begin
                s = d[15] ? int'(u) - 65536 : int'(u);
                if (s >= 0) q = s / int'(p);
                else q = -((-s + int'(p) - 1) / int'(p));
                return 16'(q);
            end
            2'd2: return 16'((u / p) + (u % p) * (65536 / p));
            default: return d;
        endcase
    endfunction

    task automatic check_all();
        chk("valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("we", {31'd0, out_we}, {31'd0, m_we});
        if (m_valid) begin
            chk("result", {16'd0, out_result}, {16'd0, m_result});
            chk("dst", {28'd0, out_dst}, {28'd0, m_dst});
        end
        chk("flag_z", {31'd0, flag_z}, {31'd0, m_z});
        chk("cnt", {16'd0, shift_cnt}, m_cnt % 65536);
        chk("flag_z_w2", {31'd0, flag_z2}, {31'd0, m_z2});
        chk("cnt_w2", {30'd0, shift_cnt2}, m_cnt % 4);
    endtask

    // Advance one clock edge, update the model from the inputs held across it, compare.
    task automatic cycle();
        logic [15:0] r;
        logic        legal;
        r = ref_shift(in_op, in_data, in_imm);
        legal = (in_op != 2'b11);
        @(posedge clk);
        #1;
        if (flush) begin
            m_valid = 1'b0;
            m_we    = 1'b0;
        end else if (!stall) begin
            m_valid  = in_valid;
            m_result = r;
            m_dst    = in_dst;
            m_we     = in_valid && legal;
            if (in_valid && legal) begin
                m_z  = (r == 16'h0);
                m_z2 = (r == 16'h0);
                m_cnt++;
            end
        end
        check_all();
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [15:0] d,
                         input logic [3:0] n, input logic [3:0] dst,
                         input logic st, input logic fl);
        in_valid = v; in_op = op; in_data = d; in_imm = n; in_dst = dst;
        stall = st; flush = fl;
    endtask

    // Assert reset between edges and check outputs clear without waiting for a clock.
    task automatic apply_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", {16'd0, out_result}, 32'd0);
        chk("rst_dst", {28'd0, out_dst}, 32'd0);
        chk("rst_we", {31'd0, out_we}, 32'd0);
        chk("rst_z", {31'd0, flag_z}, 32'd0);
        chk("rst_cnt", {16'd0, shift_cnt}, 32'd0);
        chk("rst_z_w2", {31'd0, flag_z2}, 32'd1);
        chk("rst_cnt_w2", {30'd0, shift_cnt2}, 32'd0);
        m_valid = 1'b0; m_we = 1'b0; m_result = 16'h0; m_dst = 4'h0;
        m_z = 1'b0; m_z2 = 1'b1; m_cnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [15:0] data;
        logic [3:0]  imm;
        logic [15:0] res;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{2'd0, 16'h0001, 4'd15, 16'h8000};
        tbl[1] = '{2'd0, 16'h8000, 4'd1,  16'h0000};
        tbl[2] = '{2'd1, 16'h8000, 4'd15, 16'hFFFF};
        tbl[3] = '{2'd1, 16'h4000, 4'd14, 16'h0001};
        tbl[4] = '{2'd2, 16'h0001, 4'd1,  16'h8000};
        tbl[5] = '{2'd2, 16'h1234, 4'd0,  16'h1234};
        tbl[6] = '{2'd0, 16'hA5A5, 4'd0,  16'hA5A5};
        tbl[7] = '{2'd1, 16'h8001, 4'd0,  16'h8001};
        tbl[8] = '{2'd1, 16'h8F00, 4'd4,  16'hF8F0};
        tbl[9] = '{2'd2, 16'h00F1, 4'd4,  16'h100F};

        drive(1'b0, 2'd0, 16'h0, 4'd0, 4'd0, 1'b0, 1'b0);
        #1;
        apply_reset();

        // Directed vectors, one per cycle with distinct destinations.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, tbl[i].op, tbl[i].data, tbl[i].imm, 4'(i), 1'b0, 1'b0);
            cycle();
            chk("tbl_result", {16'd0, out_result}, {16'd0, tbl[i].res});
            chk("tbl_z", {31'd0, flag_z}, {31'd0, (tbl[i].res == 16'h0)});
            if (i == 1) chk("tbl_cnt2", {16'd0, shift_cnt}, 32'd2);
        end

        // Stall holds everything for three cycles, then the next input is captured.
        drive(1'b1, 2'd0, 16'h00F0, 4'd4, 4'd3, 1'b0, 1'b0);
        cycle();
        chk("stall_pre", {16'd0, out_result}, 32'h0F00);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd0, 16'hFFFF, 4'd0, 4'd9, 1'b1, 1'b0);
            cycle();
            chk("stall_hold", {16'd0, out_result}, 32'h0F00);
            chk("stall_dst", {28'd0, out_dst}, 32'd3);
        end
        drive(1'b1, 2'd2, 16'h0003, 4'd1, 4'd5, 1'b0, 1'b0);
        cycle();
        chk("stall_release", {16'd0, out_result}, 32'h8001);

        // Flush together with stall on a zero-result shift: squashed, Z keeps prior 0.
        drive(1'b1, 2'd0, 16'h0000, 4'd2, 4'd6, 1'b1, 1'b1);
        cycle();
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_we", {31'd0, out_we}, 32'd0);
        chk("flush_z", {31'd0, flag_z}, 32'd0);

        // Illegal op on zero data: valid but no write, Z untouched.
        drive(1'b1, 2'd3, 16'h0000, 4'd7, 4'd7, 1'b0, 1'b0);
        cycle();
        chk("ill_valid", {31'd0, out_valid}, 32'd1);
        chk("ill_we", {31'd0, out_we}, 32'd0);
        chk("ill_z", {31'd0, flag_z}, 32'd0);
        chk("ill_result", {16'd0, out_result}, 32'd0);

        // Reset during stall+flush, then four legal shifts wrap the 2-bit counter.
        drive(1'b1, 2'd0, 16'h0001, 4'd1, 4'd1, 1'b1, 1'b1);
        #2;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(i % 3), 16'h0010, 4'(i), 4'(i), 1'b0, 1'b0);
            cycle();
        end
        chk("wrap_cnt_w2", {30'd0, shift_cnt2}, 32'd0);
        chk("wrap_cnt", {16'd0, shift_cnt}, 32'd4);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom),
                  4'($urandom), 4'($urandom),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 9) == 0));
            cycle();
            if (i == 200) begin
                #2;
                apply_reset();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_shift_stage.md
Name: ex_shift_stage

Overview:
Execute-stage shift unit for the 16-bit pipeline. It consumes decoded shift instructions from the ID/EX boundary and computes SLL, SRA or ROR in one cycle. It uses the combinational Shifter for SLL/SRA and local logic for ROR. The result is registered into the EX/MEM boundary and the architectural Z flag is updated; stall, flush and a retired-shift counter are handled locally.

Parameters:
CNT_W, 16, width of retired-shift performance counter (wraps modulo 2^CNT_W)
Z_RESET, 1'b0, reset value of the Z flag register

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  ID/EX holds a shift-class instruction this cycle
in_op  input  2  00=SLL, 01=SRA, 10=ROR, 11=illegal
in_data  input  16  source operand (already forwarded)
in_imm  input  4  shift amount 0..15
in_dst  input  4  destination register index
stall  input  1  hazard unit: hold EX/MEM contents
flush  input  1  hazard unit: squash instruction entering EX/MEM
out_valid  output  1  EX/MEM holds a valid shift result
out_result  output  16  registered shift result
out_dst  output  4  registered destination index
out_we  output  1  register-file write enable for this result
flag_z  output  1  architectural Z flag
shift_cnt  output  CNT_W  count of retired valid legal shifts

Behaviour:
- Reset (rst_n low, async): out_valid=0, out_result=16'h0000, out_dst=4'h0, out_we=0, flag_z=Z_RESET, shift_cnt=0. All outputs take these values immediately on assert, independent of clk.
- Datapath (combinational, same cycle as in_valid):
  - SLL/SRA: instance of Shifter with Mode = in_op[0].
  - ROR: (in_data >> n) | (in_data << (16-n)), with n=0 giving in_data unchanged.
  - Illegal op: result = in_data.
- Latency: 1 cycle, in_valid at edge k -> out_* valid after edge k+1.
- Per rising edge, evaluate in this priority:
  1. flush=1: out_valid<=0, out_we<=0. out_result and out_dst may hold; flag_z and shift_cnt unchanged. Flush beats stall.
  2. stall=1: all output registers, flag_z and shift_cnt hold.
  3. Otherwise: out_valid<=in_valid; out_result<=computed result; out_dst<=in_dst.
     - out_we<=in_valid & (in_op!=11).
     - If in_valid and op legal: flag_z<=(result==0) and shift_cnt<=shift_cnt+1, wrapping from all-ones to 0.
     - Illegal op: out_valid=1, out_we=0, Z and counter unchanged.
     - in_valid=0: bubble, out_we=0, Z unchanged.
- Boundary cases:
  - Shift amount 0: all three ops pass in_data through; Z still updates.
  - SRA fills with bit 15. SLL fills with zeros.
  - Stall and flush both high: treated as flush.
  - Reset mid-stall or mid-flush: reset wins.
  - First edge after rst_n deassert behaves per the normal rules.

Test Plan:
1. Reset: rst_n=0 between edges -> outputs clear immediately; flag_z=Z_RESET, shift_cnt=0.
2. SLL in_data=16'h0001, imm=15 -> out_result=16'h8000, flag_z=0, out_we=1. Then SLL 16'h8000, imm=1 -> 16'h0000, flag_z=1, shift_cnt=2.
3. SRA 16'h8000, imm=15 -> 16'hFFFF. SRA 16'h4000, imm=14 -> 16'h0001. ROR 16'h0001, imm=1 -> 16'h8000. ROR 16'h1234, imm=0 -> 16'h1234. All with one-cycle latency.
4. Stall: SLL 16'h00F0 by 4 retired (out=16'h0F00), then stall=1 for 3 cycles with new in_data=16'hFFFF -> out_result stays 16'h0F00, flag_z and shift_cnt unchanged; next non-stalled valid input is captured.
5. Flush with stall simultaneously, in_valid=1, result 0 -> out_valid=0, out_we=0, flag_z keeps its prior value, shift_cnt unchanged.
6. Illegal op 11, in_data=16'h0000 -> out_valid=1, out_we=0, flag_z unchanged. Separately, with CNT_W=2, 4 legal shifts wrap shift_cnt back to 0.
